if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register of the MIPS pipeline, sitting directly upstream of the ID/EX register. It owns the PC, presents fetch addresses to the instruction cache, and captures returned instructions into the IF/ID register. It handles cache misses (`hit` low), hazard stalls and taken-branch redirects, and keeps fetch/miss performance counters. `if_next_pc` is the PC+4 value that decode forwards to `next_pc` of ID/EX.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `hit` input 1: instruction cache hit; `icache_data` is valid for the current `icache_addr` in this cycle.
- `icache_data` input 32: instruction word returned by the cache, combinational to `icache_addr`.
- `stall` input 1: hazard-unit freeze (load-use); holds PC and IF/ID.
- `branch_taken` input 1: single-cycle redirect request from the branch-resolve stage.
- `branch_target` input 32: redirect address; bits [1:0] ignored and forced to 0.
- `icache_addr` output 32: current PC.
- `icache_req` output 1: fetch request valid.
- `if_instr` output 32: IF/ID instruction.
- `if_next_pc` output 32: IF/ID PC+4 of the captured instruction.
- `if_valid` output 1: IF/ID holds a real instruction (0 = bubble).
- `fetch_count` output 32: instructions delivered, wraps.
- `miss_count` output 16: MISS-state cycles, saturates at 16'hFFFF.

## Operation
- FSM states:
  - IDLE: entered on reset.
  - FETCH: normal fetch.
  - MISS: waiting on the cache.
- `icache_req` is 0 in IDLE and 1 in FETCH and MISS.
- IDLE always goes to FETCH on the next edge; PC and IF/ID hold while in IDLE.
- In FETCH/MISS, evaluate once per edge with priority `branch_taken` > `stall` > `hit`:
  - `branch_taken`=1 (any state except IDLE): PC <= {branch_target[31:2],2'b00}; IF/ID flushed (`if_instr`=0, `if_next_pc`=0, `if_valid`=0); state <= FETCH; the current `hit` is ignored.
  - `stall`=1: PC and IF/ID hold; state holds; counters hold, except that `miss_count` increments if state is MISS.
  - `hit`=0: PC holds; IF/ID loads a bubble (`if_instr`=0, i.e. NOP, `if_valid`=0, `if_next_pc`=0); state <= MISS.
  - `hit`=1: `if_instr` <= `icache_data`; `if_next_pc` <= PC+4; `if_valid` <= 1; PC <= PC+4; `fetch_count` += 1; state <= FETCH.
- `miss_count` increments on every edge where the state is MISS before the edge, unless `branch_taken`=1.
- PC arithmetic is modulo 2^32: PC 32'hFFFF_FFFC + 4 gives 0. `if_next_pc` wraps the same way.
- Reset (async, any cycle, including mid-miss):
  - PC = `RESET_PC`.
  - state = IDLE.
  - `if_instr`=0, `if_next_pc`=0, `if_valid`=0.
  - `fetch_count`=0, `miss_count`=0.
  - `icache_req`=0.

## Timing
- Outputs are registered except `icache_addr` (= PC register) and `icache_req` (decoded from the state register).
- Fetch latency: an address presented with `hit`=1 in cycle N gives `if_instr`/`if_valid`=1 after edge N+1. The next address appears on `icache_addr` in the same edge.
- Throughput: 1 instruction/cycle when `hit`=1 and `stall`=0.
- First `icache_req`=1 occurs one cycle after `rst_n` deasserts.
- A taken-branch penalty is one bubble in IF/ID. `branch_target` appears on `icache_addr` the cycle after `branch_taken`.
- Simultaneous `branch_taken` and `stall`: redirect wins. The IF/ID flush overrides the freeze.
- A miss resolving (`hit` 0→1) in cycle M delivers the instruction at edge M+1, with state back to FETCH.
- `miss_count` stays at 16'hFFFF once saturated, until reset.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.

## Test plan
- **Reset:** `RESET_PC`=32'h0000_0040, hold `rst_n`=0 then release, `hit`=1 → one cycle with `icache_req`=0 and addr 0x40. Then `if_instr` = data@0x40, `if_next_pc`=0x44, `if_valid`=1; addr sequence 0x44, 0x48.
- **Miss:** at PC 0x08 drive `hit`=0 for 3 cycles → addr stays 0x08, `if_valid`=0 for 3 cycles, `miss_count`=2 (MISS cycles counted from the second). On `hit`=1, `if_next_pc`=0x0C.
- **Stall:** `stall`=1 for 2 cycles while `if_valid`=1 with instr 0x8C22_0004 → IF/ID and addr unchanged, `fetch_count` unchanged.
- **Branch:** `branch_taken`=1, `branch_target`=32'h0000_0103, together with `stall`=1 and `hit`=1 → next cycle addr=0x100, `if_valid`=0, `if_instr`=0.
- **Branch mid-miss, then reset:** `branch_taken` during MISS → FETCH, no `miss_count` increment. Then assert `rst_n`=0 mid-miss → all outputs immediately at reset values.
- **Wrap:** `branch_target`=32'hFFFF_FFFC, `hit`=1 → `if_next_pc`=0, next addr=0.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, drives the
// instruction cache, handles misses/stalls/redirects and keeps fetch/miss counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit,
  input  logic [31:0] icache_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] icache_addr,
  output logic        icache_req,
  output logic [31:0] if_instr,
  output logic [31:0] if_next_pc,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MISS  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [15:0] mcnt_q, mcnt_d;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state decode: branch_taken beats stall, stall beats hit.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH, MISS: begin
        if (branch_taken) begin
          pc_d    = {branch_target[31:2], 2'b00};
          instr_d = 32'd0;
          npc_d   = 32'd0;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (stall) begin
          state_d = state_q;
        end else if (!hit) begin
          instr_d = 32'd0;
          npc_d   = 32'd0;
          valid_d = 1'b0;
          state_d = MISS;
        end else begin
          instr_d = icache_data;
          npc_d   = pc_plus4_s;
          valid_d = 1'b1;
          pc_d    = pc_plus4_s;
          fcnt_d  = fcnt_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Every MISS cycle counts, including stalled ones, unless redirected away.
    if ((state_q == MISS) && !branch_taken && (mcnt_q != 16'hFFFF)) begin
      mcnt_d = mcnt_q + 16'd1;
    end else begin
      mcnt_d = mcnt_q;
    end
  end

  // State, PC, IF/ID and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      fcnt_q  <= 32'd0;
      mcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign icache_addr = pc_q;
  assign icache_req  = (state_q != IDLE);
  assign if_instr    = instr_q;
  assign if_next_pc  = npc_q;
  assign if_valid    = valid_q;
  assign fetch_count = fcnt_q;
  assign miss_count  = mcnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: table of vectors pushed through a scoreboard queue,
// plus hand sequences for reset release, reset mid-miss and miss_count saturation.
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        hit;
  logic [31:0] icache_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] if_instr;
  logic [31:0] if_next_pc;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  if_id_stage #(.RESET_PC(32'h0000_0040)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hit          (hit),
    .icache_data  (icache_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .icache_addr  (icache_addr),
    .icache_req   (icache_req),
    .if_instr     (if_instr),
    .if_next_pc   (if_next_pc),
    .if_valid     (if_valid),
    .fetch_count  (fetch_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h8C22_0004;
    else return a ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory model answering the current fetch address.
  assign icache_data = mem_word(icache_addr);

  typedef struct {
    logic        hit;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic [31:0] e_fc;
    logic [15:0] e_mc;
  } vec_t;

  vec_t vecs[22];
  vec_t sb[$];

  function automatic vec_t mk(input logic h, input logic s, input logic b, input logic [31:0] t,
                              input logic [31:0] a, input logic v, input logic [31:0] ins,
                              input logic [31:0] np, input logic [31:0] fc, input logic [15:0] mc);
    vec_t r;
    r.hit = h; r.stall = s; r.br = b; r.tgt = t;
    r.e_addr = a; r.e_valid = v; r.e_instr = ins; r.e_npc = np; r.e_fc = fc; r.e_mc = mc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    hit = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req",   {31'd0, icache_req}, 32'd0);
    chk("rst_addr",  icache_addr, 32'h40);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_npc",   if_next_pc, 32'd0);
    chk("rst_fc",    fetch_count, 32'd0);
    chk("rst_mc",    {16'd0, miss_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("idle_exit_req",   {31'd0, icache_req}, 32'd1);
    chk("idle_exit_addr",  icache_addr, 32'h40);
    chk("idle_exit_valid", {31'd0, if_valid}, 32'd0);

    //              hit   stall br    tgt           addr          v     instr                     npc           fc     mc
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h44,       1'b1, mem_word(32'h40),         32'h44,       32'd1, 16'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h48,       1'b1, mem_word(32'h44),         32'h48,       32'd2, 16'd0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 32'h08,       32'h08,       1'b0, 32'h0,                    32'h0,        32'd2, 16'd0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h08,       1'b0, 32'h0,                    32'h0,        32'd2, 16'd0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h08,       1'b0, 32'h0,                    32'h0,        32'd2, 16'd1);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h08,       1'b0, 32'h0,                    32'h0,        32'd2, 16'd2);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h0C,       1'b1, mem_word(32'h08),         32'h0C,       32'd3, 16'd3);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h10,       1'b1, 32'h8C22_0004,            32'h10,       32'd4, 16'd3);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        32'h10,       1'b1, 32'h8C22_0004,            32'h10,       32'd4, 16'd3);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h10,       1'b1, 32'h8C22_0004,            32'h10,       32'd4, 16'd3);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h14,       1'b1, mem_word(32'h10),         32'h14,       32'd5, 16'd3);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'h103,      32'h100,      1'b0, 32'h0,                    32'h0,        32'd5, 16'd3);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h104,      1'b1, mem_word(32'h100),        32'h104,      32'd6, 16'd3);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h104,      1'b0, 32'h0,                    32'h0,        32'd6, 16'd3);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h104,      1'b0, 32'h0,                    32'h0,        32'd6, 16'd4);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h200,      32'h200,      1'b0, 32'h0,                    32'h0,        32'd6, 16'd4);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h204,      1'b1, mem_word(32'h200),        32'h204,      32'd7, 16'd4);
    vecs[17] = mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0,                   32'h0,        32'd7, 16'd4);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, mem_word(32'hFFFF_FFFC),  32'h0,        32'd8, 16'd4);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, mem_word(32'h0),          32'h4,        32'd9, 16'd4);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b0, 32'h0,                    32'h0,        32'd9, 16'd4);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b0, 32'h0,                    32'h0,        32'd9, 16'd5);

    for (int i = 0; i < 22; i++) begin
      hit = vecs[i].hit; stall = vecs[i].stall;
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      sb.push_back(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_addr", i),  icache_addr, e.e_addr);
      chk($sformatf("v%0d_req", i),   {31'd0, icache_req}, 32'd1);
      chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, e.e_valid});
      chk($sformatf("v%0d_instr", i), if_instr, e.e_instr);
      chk($sformatf("v%0d_npc", i),   if_next_pc, e.e_npc);
      chk($sformatf("v%0d_fc", i),    fetch_count, e.e_fc);
      chk($sformatf("v%0d_mc", i),    {16'd0, miss_count}, {16'd0, e.e_mc});
    end
    branch_taken = 1'b0; stall = 1'b0; hit = 1'b0;

    // Asynchronous reset while in MISS, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr",  icache_addr, 32'h40);
    chk("arst_req",   {31'd0, icache_req}, 32'd0);
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    chk("arst_npc",   if_next_pc, 32'd0);
    chk("arst_fc",    fetch_count, 32'd0);
    chk("arst_mc",    {16'd0, miss_count}, 32'd0);

    // Saturation: 1 IDLE edge, then 65535 miss edges -> 65534 counted.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    chk("sat_pre_mc", {16'd0, miss_count}, 32'h0000_FFFE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sat_mc",    {16'd0, miss_count}, 32'h0000_FFFF);
    chk("sat_addr",  icache_addr, 32'h40);
    chk("sat_valid", {31'd0, if_valid}, 32'd0);
    chk("sat_fc",    fetch_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
